// File: rtl/thcomp_mc_pkg.sv
// Shared definitions for the multi-channel threshold comparator: FSM states,
// register map, MODE bit positions and reset defaults.
package thcomp_mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned ADDR_TH_HI   = 0;
    localparam int unsigned ADDR_TH_LO   = 1;
    localparam int unsigned ADDR_HIT_CNT = 2;
    localparam int unsigned ADDR_MODE    = 3;
    localparam int unsigned ADDR_STATUS  = 4;

    localparam int unsigned MODE_SIGNED = 0;
    localparam int unsigned MODE_HYST   = 1;
    localparam int unsigned MODE_SCLR   = 2;

    localparam int unsigned RST_TH_HI   = 0;
    localparam int unsigned RST_TH_LO   = 0;
    localparam int unsigned RST_HIT_CNT = 1;
    localparam int unsigned RST_MODE    = 0;

endpackage

// File: rtl/thcomp_ch_eval.sv
// Combinational single-channel evaluator: threshold crossing with optional
// hysteresis and signed compare, plus consecutive-hit qualification.
module thcomp_ch_eval #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 4
) (
    input  logic [WIDTH-1:0] i_sample,
    input  logic             i_d,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic [WIDTH-1:0] i_th_hi,
    input  logic [WIDTH-1:0] i_th_lo,
    input  logic [CNT_W-1:0] i_hit_cnt,
    input  logic             i_signed,
    input  logic             i_hyst,
    output logic             o_d,
    output logic [CNT_W-1:0] o_cnt
);

    logic             w_gt_hi;
    logic             w_lt_lo;
    logic             w_cross;
    logic [CNT_W-1:0] w_hit_eff;
    logic [CNT_W:0]   w_cnt_inc;

    always_comb begin
        w_gt_hi = i_signed ? ($signed(i_sample) > $signed(i_th_hi)) : (i_sample > i_th_hi);
        w_lt_lo = i_signed ? ($signed(i_sample) < $signed(i_th_lo)) : (i_sample < i_th_lo);
        if (i_d) begin
            w_cross = i_hyst ? w_lt_lo : !w_gt_hi;
        end else begin
            w_cross = w_gt_hi;
        end
    end

    // HIT_CNT of 0 behaves as 1; the increment is one bit wider so the compare never wraps
    assign w_hit_eff = (i_hit_cnt == '0) ? CNT_W'(1) : i_hit_cnt;
    assign w_cnt_inc = {1'b0, i_cnt} + (CNT_W+1)'(1);

    always_comb begin
        o_d   = i_d;
        o_cnt = '0;
        if (w_cross) begin
            if (w_cnt_inc >= {1'b0, w_hit_eff}) begin
                o_d   = !i_d;
                o_cnt = '0;
            end else begin
                o_cnt = (i_cnt == '1) ? i_cnt : i_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/thcomp_mc.sv
// Multi-channel threshold comparator: captures a frame of samples and evaluates
// channels serially through one shared evaluator, then reports the decision vector.
module thcomp_mc
    import thcomp_mc_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned N_CH   = 4,
    parameter int unsigned CNT_W  = 4,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ematop_thcompmc_start,
    input  logic [N_CH*WIDTH-1:0] ematop_thcompmc_data,
    input  logic                  cfg_we,
    input  logic [ADDR_W-1:0]     cfg_addr,
    input  logic [WIDTH-1:0]      cfg_data_in,
    output logic [WIDTH-1:0]      cfg_data_out,
    output logic [N_CH-1:0]       thcompmc_ctrltop_data,
    output logic                  thcompmc_ctrltop_finish,
    output logic                  thcompmc_ctrltop_busy
);

    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CH_W-1:0]       r_ch;
    logic [N_CH*WIDTH-1:0] r_data;
    logic [WIDTH-1:0]      r_th_hi, r_th_lo, r_snap_hi, r_snap_lo;
    logic [CNT_W-1:0]      r_hit_cnt, r_snap_hit;
    logic [1:0]            r_mode, r_snap_mode;
    logic [N_CH-1:0]       r_d, r_out, w_d_upd;
    logic [CNT_W-1:0]      r_cnt [N_CH];
    logic                  w_last, w_sclr, w_d_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [WIDTH-1:0]      w_rd;

    assign w_last = (r_ch == CH_W'(N_CH-1));
    assign w_sclr = cfg_we && (cfg_addr == ADDR_W'(ADDR_MODE)) &&
                    cfg_data_in[MODE_SCLR] && (r_state == ST_IDLE);

    thcomp_ch_eval #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_eval (
        .i_sample  (r_data[r_ch*WIDTH +: WIDTH]),
        .i_d       (r_d[r_ch]),
        .i_cnt     (r_cnt[r_ch]),
        .i_th_hi   (r_snap_hi),
        .i_th_lo   (r_snap_lo),
        .i_hit_cnt (r_snap_hit),
        .i_signed  (r_snap_mode[MODE_SIGNED]),
        .i_hyst    (r_snap_mode[MODE_HYST]),
        .o_d       (w_d_nxt),
        .o_cnt     (w_cnt_nxt)
    );

    always_comb begin
        w_d_upd       = r_d;
        w_d_upd[r_ch] = w_d_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (ematop_thcompmc_start) w_state_nxt = ST_CMP;
            ST_CMP:  if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch        <= '0;
            r_data      <= '0;
            r_th_hi     <= WIDTH'(RST_TH_HI);
            r_th_lo     <= WIDTH'(RST_TH_LO);
            r_hit_cnt   <= CNT_W'(RST_HIT_CNT);
            r_mode      <= 2'(RST_MODE);
            r_snap_hi   <= WIDTH'(RST_TH_HI);
            r_snap_lo   <= WIDTH'(RST_TH_LO);
            r_snap_hit  <= CNT_W'(RST_HIT_CNT);
            r_snap_mode <= 2'(RST_MODE);
            r_d         <= '0;
            r_out       <= '0;
            for (int unsigned i = 0; i < N_CH; i++) r_cnt[i] <= '0;
        end else begin
            if (cfg_we) begin
                case (cfg_addr)
                    ADDR_W'(ADDR_TH_HI):   r_th_hi   <= cfg_data_in;
                    ADDR_W'(ADDR_TH_LO):   r_th_lo   <= cfg_data_in;
                    ADDR_W'(ADDR_HIT_CNT): r_hit_cnt <= cfg_data_in[CNT_W-1:0];
                    ADDR_W'(ADDR_MODE):    r_mode    <= cfg_data_in[1:0];
                    default: ;
                endcase
            end
            // Soft-clear is gated to IDLE, so it never collides with CMP updates
            if (w_sclr) begin
                r_d <= '0;
                for (int unsigned i = 0; i < N_CH; i++) r_cnt[i] <= '0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (ematop_thcompmc_start) begin
                        r_data      <= ematop_thcompmc_data;
                        r_snap_hi   <= r_th_hi;
                        r_snap_lo   <= r_th_lo;
                        r_snap_hit  <= r_hit_cnt;
                        r_snap_mode <= r_mode;
                        r_ch        <= '0;
                    end
                end
                ST_CMP: begin
                    r_d         <= w_d_upd;
                    r_cnt[r_ch] <= w_cnt_nxt;
                    if (w_last) r_out <= w_d_upd;
                    else        r_ch  <= r_ch + CH_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rd = '0;
        case (cfg_addr)
            ADDR_W'(ADDR_TH_HI):   w_rd = r_th_hi;
            ADDR_W'(ADDR_TH_LO):   w_rd = r_th_lo;
            ADDR_W'(ADDR_HIT_CNT): w_rd[CNT_W-1:0] = r_hit_cnt;
            ADDR_W'(ADDR_MODE):    w_rd[1:0] = r_mode;
            ADDR_W'(ADDR_STATUS):  w_rd[N_CH-1:0] = r_d;
            default:               w_rd = '0;
        endcase
    end

    assign cfg_data_out            = w_rd;
    assign thcompmc_ctrltop_data   = r_out;
    assign thcompmc_ctrltop_finish = (r_state == ST_DONE);
    assign thcompmc_ctrltop_busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_thcomp_mc.sv
// Directed self-checking bench for thcomp_mc (WIDTH=16, N_CH=4).
module tb_thcomp_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] data = '0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [15:0] cfg_data_in = '0;
    logic [15:0] cfg_data_out;
    logic [3:0]  dout;
    logic        finish;
    logic        busy;

    int checks = 0;
    int failures = 0;

    thcomp_mc #(.WIDTH(16), .N_CH(4), .CNT_W(4), .ADDR_W(3)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .ematop_thcompmc_start   (start),
        .ematop_thcompmc_data    (data),
        .cfg_we                  (cfg_we),
        .cfg_addr                (cfg_addr),
        .cfg_data_in             (cfg_data_in),
        .cfg_data_out            (cfg_data_out),
        .thcompmc_ctrltop_data   (dout),
        .thcompmc_ctrltop_finish (finish),
        .thcompmc_ctrltop_busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_data_in = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] v);
        cfg_addr = a;
        #1 v = cfg_data_out;
    endtask

    // Starts a frame and returns at the negedge of the finish cycle (bounded wait)
    task automatic frame(input string tag, input logic [63:0] v, input logic [3:0] exp);
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        start = 1'b1; data = v;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (finish) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_finish"}, {31'b0, seen}, 32'd1);
        chk({tag, "_data"}, {28'b0, dout}, {28'b0, exp});
    endtask

    initial begin
        logic [15:0] r;
        int nfin;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_data", {28'b0, dout}, 32'h0);
        chk("rst_finish", {31'b0, finish}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        rd(3'd2, r); chk("rst_hitcnt", {16'b0, r}, 32'h1);
        rd(3'd5, r); chk("rst_unmapped", {16'b0, r}, 32'h0);
        rd(3'd0, r); chk("rst_th_hi", {16'b0, r}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency: start at T, busy T+1..T+5, finish only at T+5
        wr(3'd0, 16'd100);
        @(negedge clk);
        start = 1'b1; data = {16'd50, 16'd50, 16'd50, 16'd101};
        @(negedge clk);
        start = 1'b0;
        chk("lat_busy_t1", {31'b0, busy}, 32'd1);
        chk("lat_fin_t1", {31'b0, finish}, 32'd0);
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            chk("lat_busy_mid", {31'b0, busy}, 32'd1);
            chk("lat_fin_mid", {31'b0, finish}, 32'd0);
        end
        @(negedge clk);
        chk("lat_fin_t5", {31'b0, finish}, 32'd1);
        chk("lat_busy_t5", {31'b0, busy}, 32'd1);
        chk("lat_data_t5", {28'b0, dout}, 32'h1);
        @(negedge clk);
        chk("lat_fin_t6", {31'b0, finish}, 32'd0);
        chk("lat_busy_t6", {31'b0, busy}, 32'd0);
        chk("lat_data_hold", {28'b0, dout}, 32'h1);
        rd(3'd4, r); chk("lat_status", {16'b0, r}, 32'h1);

        // Consecutive-hit qualification, HIT_CNT=3; ch0=101 keeps d0=1
        wr(3'd2, 16'd3);
        frame("hit_a", {16'd50, 16'd50, 16'd200, 16'd101}, 4'b0001);
        frame("hit_b", {16'd50, 16'd50, 16'd200, 16'd101}, 4'b0001);
        frame("hit_break", {16'd50, 16'd50, 16'd50, 16'd101}, 4'b0001);
        frame("hit_c", {16'd50, 16'd50, 16'd200, 16'd101}, 4'b0001);
        frame("hit_d", {16'd50, 16'd50, 16'd200, 16'd101}, 4'b0001);
        frame("hit_e", {16'd50, 16'd50, 16'd200, 16'd101}, 4'b0011);

        // Soft-clear in IDLE clears d but leaves the held output; bit2 reads 0
        wr(3'd2, 16'd1);
        wr(3'd3, 16'h0004);
        rd(3'd4, r); chk("sclr_status", {16'b0, r}, 32'h0);
        rd(3'd3, r); chk("sclr_mode_rd", {16'b0, r}, 32'h0);
        chk("sclr_out_held", {28'b0, dout}, 32'h3);

        // Hysteresis
        wr(3'd1, 16'd80);
        wr(3'd3, 16'h0002);
        frame("hy_set", {16'd50, 16'd50, 16'd50, 16'd101}, 4'b0001);
        frame("hy_90", {16'd50, 16'd50, 16'd50, 16'd90}, 4'b0001);
        frame("hy_79", {16'd50, 16'd50, 16'd50, 16'd79}, 4'b0000);
        frame("hy_set2", {16'd50, 16'd50, 16'd50, 16'd101}, 4'b0001);
        wr(3'd3, 16'h0000);
        frame("nohy_90", {16'd50, 16'd50, 16'd50, 16'd90}, 4'b0000);

        // Signed vs unsigned compare, TH_HI=-16
        wr(3'd0, 16'hFFF0);
        wr(3'd3, 16'h0001);
        frame("sgn_fff8", {16'h8000, 16'h8000, 16'h8000, 16'hFFF8}, 4'b0001);
        wr(3'd3, 16'h0004);
        frame("uns_0008", {16'h8000, 16'h8000, 16'h8000, 16'h0008}, 4'b0000);
        wr(3'd3, 16'h0001);
        frame("sgn_0008", {16'h8000, 16'h8000, 16'h8000, 16'h0008}, 4'b0001);

        // start during CMP is ignored: one finish only
        wr(3'd3, 16'h0004);
        wr(3'd0, 16'd100);
        nfin = 0;
        @(negedge clk);
        start = 1'b1; data = {16'd50, 16'd50, 16'd50, 16'd101};
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (finish) nfin++;
            @(negedge clk);
        end
        chk("dbl_start_nfin", nfin, 32'd1);
        chk("dbl_start_data", {28'b0, dout}, 32'h1);
        chk("dbl_start_idle", {31'b0, busy}, 32'd0);

        // Soft-clear while busy is ignored
        @(negedge clk);
        start = 1'b1; data = {16'd50, 16'd50, 16'd50, 16'd101};
        @(negedge clk);
        start = 1'b0;
        cfg_we = 1'b1; cfg_addr = 3'd3; cfg_data_in = 16'h0004;
        @(negedge clk);
        cfg_we = 1'b0;
        nfin = 0;
        for (int i = 0; i < 12; i++) begin
            if (finish) nfin++;
            @(negedge clk);
        end
        chk("busy_sclr_nfin", nfin, 32'd1);
        chk("busy_sclr_data", {28'b0, dout}, 32'h1);
        rd(3'd4, r); chk("busy_sclr_status", {16'b0, r}, 32'h1);

        // Reset mid-frame aborts without finish
        wr(3'd2, 16'd5);
        @(negedge clk);
        start = 1'b1; data = {16'd200, 16'd200, 16'd200, 16'd200};
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        nfin = 0;
        for (int i = 0; i < 8; i++) begin
            if (finish) nfin++;
            @(negedge clk);
        end
        chk("mid_rst_nfin", nfin, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_data", {28'b0, dout}, 32'h0);
        rd(3'd4, r); chk("mid_rst_status", {16'b0, r}, 32'h0);
        rd(3'd2, r); chk("mid_rst_hitcnt", {16'b0, r}, 32'h1);
        rd(3'd0, r); chk("mid_rst_th_hi", {16'b0, r}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
